morse_decoder: RTL and testbench

//  Receive side of the Morse link: samples a single on/off Morse line (the led output of
//  led_morsecode, or a telegraph key), classifies marks as dot/dash and gaps as symbol/char

---
 rtl/morse_decoder.sv | 197 +++++++++++++++++++
 tb/tb_morse_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Morse receiver: synchronises a mark/space line, classifies dots/dashes and gaps, and
// strobes out one character code per letter/digit. Define MORSE_DEBOUNCE_EN to add an input debounce filter.
module morse_decoder #(
    parameter int UNIT_CYCLES = 31250000
`ifdef MORSE_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 1000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       morse_in,
    output logic [5:0] char_code,
    output logic       char_valid,
    output logic       red,
    output logic       green
);
    localparam int DUR_W = $clog2(8 * UNIT_CYCLES + 1);
    localparam logic [DUR_W-1:0] DUR_MAX  = DUR_W'(8 * UNIT_CYCLES);
    localparam logic [DUR_W-1:0] DASH_MIN = DUR_W'(2 * UNIT_CYCLES);
    localparam logic [DUR_W-1:0] GAP_CHAR = DUR_W'(3 * UNIT_CYCLES);
    localparam logic [5:0]       CODE_BAD = 6'd63;

    typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;
    state_t state, state_next;

    logic             sync_a, sync_b, line_s, line_prev;
    logic [DUR_W-1:0] dur;
    logic [4:0]       sym_bits;
    logic [2:0]       sym_cnt;
    logic             ovf;
    logic [5:0]       code_reg, lookup_code;
    logic             push_sym, sym_dash, emit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= morse_in;
            sync_b <= sync_a;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt;

    // line_s follows the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_s <= 1'b0;
            db_cnt <= '0;
        end else if (sync_b == line_s) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            line_s <= sync_b;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    assign line_s = sync_b;
`endif

    // dur holds the run length of line_prev, so a level change reports the length of the run just ended
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_prev <= 1'b0;
            dur       <= '0;
        end else begin
            line_prev <= line_s;
            if (line_s != line_prev)
                dur <= DUR_W'(1);
            else if (dur != DUR_MAX)
                dur <= dur + DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        push_sym   = 1'b0;
        sym_dash   = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: if (line_s) state_next = MARK;
            MARK: begin
                if (!line_s) begin
                    push_sym   = 1'b1;
                    sym_dash   = (dur >= DASH_MIN);
                    state_next = SPACE;
                end
            end
            // a gap of exactly three units ending on a rising edge still closes the character
            SPACE: begin
                if (dur >= GAP_CHAR)
                    state_next = EMIT;
                else if (line_s)
                    state_next = MARK;
            end
            EMIT: begin
                emit       = 1'b1;
                state_next = line_s ? MARK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // key is {symbol count, symbols with the first one in the most significant used bit}
    always_comb begin
        lookup_code = CODE_BAD;
        if (!ovf) begin
            case ({sym_cnt, sym_bits})
                8'b010_00001: lookup_code = 6'd0;
                8'b100_01000: lookup_code = 6'd1;
                8'b100_01010: lookup_code = 6'd2;
                8'b011_00100: lookup_code = 6'd3;
                8'b001_00000: lookup_code = 6'd4;
                8'b100_00010: lookup_code = 6'd5;
                8'b011_00110: lookup_code = 6'd6;
                8'b100_00000: lookup_code = 6'd7;
                8'b010_00000: lookup_code = 6'd8;
                8'b100_00111: lookup_code = 6'd9;
                8'b011_00101: lookup_code = 6'd10;
                8'b100_00100: lookup_code = 6'd11;
                8'b010_00011: lookup_code = 6'd12;
                8'b010_00010: lookup_code = 6'd13;
                8'b011_00111: lookup_code = 6'd14;
                8'b100_00110: lookup_code = 6'd15;
                8'b100_01101: lookup_code = 6'd16;
                8'b011_00010: lookup_code = 6'd17;
                8'b011_00000: lookup_code = 6'd18;
                8'b001_00001: lookup_code = 6'd19;
                8'b011_00001: lookup_code = 6'd20;
                8'b100_00001: lookup_code = 6'd21;
                8'b011_00011: lookup_code = 6'd22;
                8'b100_01001: lookup_code = 6'd23;
                8'b100_01011: lookup_code = 6'd24;
                8'b100_01100: lookup_code = 6'd25;
                8'b101_11111: lookup_code = 6'd26;
                8'b101_01111: lookup_code = 6'd27;
                8'b101_00111: lookup_code = 6'd28;
                8'b101_00011: lookup_code = 6'd29;
                8'b101_00001: lookup_code = 6'd30;
                8'b101_00000: lookup_code = 6'd31;
                8'b101_10000: lookup_code = 6'd32;
                8'b101_11000: lookup_code = 6'd33;
                8'b101_11100: lookup_code = 6'd34;
                8'b101_11110: lookup_code = 6'd35;
                default:      lookup_code = CODE_BAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sym_bits <= '0;
            sym_cnt  <= '0;
            ovf      <= 1'b0;
            code_reg <= CODE_BAD;
            red      <= 1'b0;
            green    <= 1'b0;
        end else begin
            if (emit) begin
                sym_bits <= '0;
                sym_cnt  <= '0;
                ovf      <= 1'b0;
                code_reg <= lookup_code;
                green    <= (lookup_code != CODE_BAD);
                red      <= (lookup_code == CODE_BAD);
            end else if (push_sym) begin
                if (ovf || sym_cnt == 3'd5) begin
                    ovf <= 1'b1;
                end else begin
                    sym_bits <= {sym_bits[3:0], sym_dash};
                    sym_cnt  <= sym_cnt + 3'd1;
                end
            end
            if (state == MARK) begin
                red   <= 1'b0;
                green <= 1'b0;
            end
        end
    end

    assign char_valid = emit;
    assign char_code  = emit ? lookup_code : code_reg;

endmodule

// File: tb/tb_morse_decoder.sv
// Testbench for morse_decoder at UNIT_CYCLES=2: table of timed mark/space sequences plus
// hand-written reset, back-to-back and glitch sequences (debounce build uses DEBOUNCE_CYCLES=3).
module tb_morse_decoder;
    localparam int UNIT = 2;
    localparam int MAXSEG = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       morse_in;
    logic [5:0] char_code;
    logic       char_valid;
    logic       red;
    logic       green;

    always #5 clk = ~clk;

    morse_decoder #(
        .UNIT_CYCLES(UNIT)
`ifdef MORSE_DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES(3)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .morse_in(morse_in),
        .char_code(char_code),
        .char_valid(char_valid),
        .red(red),
        .green(green)
    );

    // segments alternate high/low starting high; a zero ends the list
    typedef struct {
        int seg[MAXSEG];
        int exp_strobes;
        int exp_code;
        int exp_green;
        int exp_red;
    } vec_t;

    vec_t vecs[12];
    int   nvec;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   strobe_total = 0;
    int   base;
    logic [5:0] strobe_codes[64];

    always @(negedge clk) begin
        if (char_valid === 1'b1) begin
            strobe_codes[strobe_total % 64] = char_code;
            strobe_total = strobe_total + 1;
        end
    end

    task automatic hold(input logic level, input int cycles);
        morse_in = level;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < MAXSEG && v.seg[i] != 0; i++)
            hold((i % 2) == 0, v.seg[i]);
        hold(1'b0, 6);
    endtask

    task automatic checkOutput(input string what, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s (case %0d): got %0d, expected %0d", what, idx, actual, expected);
        end
    endtask

    initial begin
`ifndef MORSE_DEBOUNCE_EN
        nvec = 12;
        vecs[0]  = '{'{2,2,6,8,0,0,0,0,0,0,0,0}, 1, 0, 1, 0};
        vecs[1]  = '{'{6,2,2,2,2,2,2,8,0,0,0,0}, 1, 1, 1, 0};
        vecs[2]  = '{'{2,2,2,2,2,2,2,2,2,8,0,0}, 1, 31, 1, 0};
        vecs[3]  = '{'{6,2,6,2,6,2,6,2,6,8,0,0}, 1, 26, 1, 0};
        vecs[4]  = '{'{2,2,2,2,2,2,2,2,2,2,2,8}, 1, 63, 0, 1};
        vecs[5]  = '{'{3,8,0,0,0,0,0,0,0,0,0,0}, 1, 4, 1, 0};
        vecs[6]  = '{'{4,8,0,0,0,0,0,0,0,0,0,0}, 1, 19, 1, 0};
        vecs[7]  = '{'{2,5,6,8,0,0,0,0,0,0,0,0}, 1, 0, 1, 0};
        vecs[8]  = '{'{6,2,2,2,6,8,0,0,0,0,0,0}, 1, 10, 1, 0};
        vecs[9]  = '{'{6,2,6,2,6,2,6,2,2,8,0,0}, 1, 35, 1, 0};
        vecs[10] = '{'{40,8,0,0,0,0,0,0,0,0,0,0}, 1, 19, 1, 0};
        vecs[11] = '{'{6,2,6,2,2,2,6,8,0,0,0,0}, 1, 16, 1, 0};
`else
        nvec = 5;
        vecs[0]  = '{'{6,8,0,0,0,0,0,0,0,0,0,0}, 1, 19, 1, 0};
        vecs[1]  = '{'{6,4,6,8,0,0,0,0,0,0,0,0}, 1, 12, 1, 0};
        vecs[2]  = '{'{40,8,0,0,0,0,0,0,0,0,0,0}, 1, 19, 1, 0};
        vecs[3]  = '{'{3,8,0,0,0,0,0,0,0,0,0,0}, 1, 4, 1, 0};
        vecs[4]  = '{'{6,3,3,8,0,0,0,0,0,0,0,0}, 1, 13, 1, 0};
`endif

        rst = 1'b0;
        morse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("reset code", 0, char_code, 63);
        checkOutput("reset valid", 0, char_valid, 0);
        checkOutput("reset green", 0, green, 0);
        checkOutput("reset red", 0, red, 0);

        for (int k = 0; k < nvec; k++) begin
            base = strobe_total;
            applyStimulus(vecs[k]);
            checkOutput("strobe count", k, strobe_total - base, vecs[k].exp_strobes);
            if (strobe_total > base)
                checkOutput("strobe code", k, strobe_codes[(strobe_total - 1) % 64], vecs[k].exp_code);
            checkOutput("held code", k, char_code, vecs[k].exp_code);
            checkOutput("green lamp", k, green, vecs[k].exp_green);
            checkOutput("red lamp", k, red, vecs[k].exp_red);
        end

        // reset in the middle of "- ." discards the partial character
        base = strobe_total;
        hold(1'b1, 6);
        hold(1'b0, 2);
        hold(1'b1, 2);
        rst = 1'b0;
        morse_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        hold(1'b0, 20);
        checkOutput("midreset strobes", 100, strobe_total - base, 0);
        checkOutput("midreset code", 100, char_code, 63);
        checkOutput("midreset green", 100, green, 0);
        checkOutput("midreset red", 100, red, 0);

        // "E", gap of exactly three units, then "T"
        base = strobe_total;
        hold(1'b1, 3);
        hold(1'b0, 6);
        hold(1'b1, 6);
        hold(1'b0, 8);
        hold(1'b0, 6);
        checkOutput("b2b strobes", 101, strobe_total - base, 2);
        checkOutput("b2b first code", 101, strobe_codes[base % 64], 4);
        checkOutput("b2b second code", 101, strobe_codes[(base + 1) % 64], 19);
        checkOutput("b2b green", 101, green, 1);

        // single-cycle high glitch inside a long low
        base = strobe_total;
        hold(1'b0, 4);
        hold(1'b1, 1);
        hold(1'b0, 10);
        hold(1'b0, 6);
`ifdef MORSE_DEBOUNCE_EN
        checkOutput("glitch strobes", 102, strobe_total - base, 0);
        checkOutput("glitch held code", 102, char_code, 19);
`else
        checkOutput("glitch strobes", 102, strobe_total - base, 1);
        checkOutput("glitch code", 102, char_code, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
